pipelined_adder_sub: RTL and testbench
======================================

# pipelined_adder_sub

Parametrised, pipelined ripple-carry adder/subtractor. Generalises the fixed 4-bit combinational ripple adder to WIDTH bits split into STAGES carry-chain slices, with one register boundary per slice, an add/subtract mode and a valid/ready stream handshake. It sits between operand producers and result consumers in datapaths where a full-width carry chain will not close timing in one cycle.

## Interface
- WIDTH, 16: operand and sum width in bits; must be a multiple of STAGES.
- STAGES, 4: number of pipeline stages (carry-chain slices), 1 to WIDTH. SLICE = WIDTH/STAGES bits per stage.
- clk  input  1  single clock; all state updates on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- carry_in  input  1  carry into bit 0; ignored when sub=1.
- sub  input  1  0: a+b+carry_in; 1: a-b (a+~b+1).
- out_valid  output  1  result beat valid.
- out_ready  input  1  consumer accepts result this cycle.
- sum  output  WIDTH  result.
- carry_out  output  1  carry out of bit WIDTH-1 (for sub: 1 = no borrow).
- overflow  output  1  signed overflow flag (see Configuration).

## Operation
- Stage k (0..STAGES-1) adds bits [k*SLICE +: SLICE] using the carry registered by stage k-1 (stage 0 uses carry_in, or 1 when sub=1).
- Operand bits for slices above k travel in skew registers; sum slices already computed travel in deskew registers, so all slices of one beat leave together.
- sub is captured with the beat; B inversion is applied per slice as the slice is added.
- Each stage holds a valid bit. Global advance enable: adv = !out_valid | out_ready. When adv=1 every stage shifts by one; when adv=0 every stage (data and valid) holds.
- in_ready = adv (combinational from out_valid, out_ready). Beat accepted when in_valid & in_ready.
- Bubbles are not collapsed; a bubble occupies a stage like a beat.
- Arithmetic is modulo 2^WIDTH; carry_out is bit WIDTH of the full sum.
- Output beats preserve input order; no beat is dropped or duplicated under any out_ready pattern.

## Timing
- Reset (rst=1 at an edge): all valid bits, sum, carry_out, overflow, and all pipeline data registers clear to 0; out_valid=0 after that edge. in_ready=1 while out_valid=0.
- Reset mid-operation: all in-flight beats are discarded; no beat accepted before reset appears on the outputs. A beat presented during the reset cycle is not accepted.
- Latency: a beat accepted at edge n appears on sum/carry_out/overflow with out_valid=1 after edge n+STAGES-1, given no stalls (STAGES=1: registered output one cycle after acceptance).
- Throughput: one beat per cycle while out_ready=1.
- Stall: while out_valid=1 and out_ready=0, outputs and all stages are stable and in_ready=0.
- Simultaneous out_valid & out_ready & in_valid: output beat retires and input beat is accepted on the same edge.

## Configuration
- Macro PIPELINED_ADDER_OVF_EN.
- Defined: overflow = 1 when the signed result is out of range (carry into MSB != carry out of MSB), registered and aligned with sum. The MSB carry-in is carried through the last stage.
- Not defined: overflow is tied to 0; no extra registers are built. Port is present in both builds.

## Test plan
- WIDTH=16, STAGES=4, out_ready=1: a=0x00FF, b=0x0001, carry_in=0, sub=0 -> after edge n+3: sum=0x0100, carry_out=0, overflow=0.
- a=0xFFFF, b=0x0001, carry_in=0 -> sum=0x0000, carry_out=1, overflow=0; a=0x7FFF, b=0x0001 -> sum=0x8000, carry_out=0, overflow=1 with PIPELINED_ADDER_OVF_EN, 0 without.
- sub=1, carry_in=1, a=0x0005, b=0x0007 -> sum=0xFFFE, carry_out=0; a=0x0007, b=0x0005 -> sum=0x0002, carry_out=1 (carry_in ignored).
- Stream 8 back-to-back beats a=i, b=0x1000*i; drop out_ready for 3 cycles after first out_valid -> in_ready=0 and outputs stable during stall; all 8 sums (0x1001*i) emerge in order, none lost or repeated.
- 3 beats in flight, assert rst for one edge -> out_valid=0, sum=0, carry_out=0 after that edge; none of the 3 beats ever appears on the outputs.
- Random sweep, WIDTH=8 with STAGES=1, 2, 8 and random in_valid/out_ready -> every result equals the reference model of a+b+carry_in / a-b, in order.

Source files
------------

// File: rtl/pipelined_adder_sub.sv
// Pipelined WIDTH-bit ripple-carry adder/subtractor, one carry-chain slice per stage, valid/ready stream.
// Optional signed-overflow flag built when PIPELINED_ADDER_OVF_EN is defined.
module pipelined_adder_sub #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry_out,
    output logic             overflow
);
    localparam int unsigned SLICE = WIDTH / STAGES;
    localparam int unsigned SW    = SLICE + 1;

    // Per-stage state; operands are kept shifted so the next slice sits in the low bits.
    logic             valid_q [STAGES];
    logic             valid_d [STAGES];
    logic             sub_q   [STAGES];
    logic             sub_d   [STAGES];
    logic             carry_q [STAGES];
    logic             carry_d [STAGES];
    logic [WIDTH-1:0] a_q     [STAGES];
    logic [WIDTH-1:0] a_d     [STAGES];
    logic [WIDTH-1:0] b_q     [STAGES];
    logic [WIDTH-1:0] b_d     [STAGES];
    logic [WIDTH-1:0] sum_q   [STAGES];
    logic [WIDTH-1:0] sum_d   [STAGES];

    // Inputs seen by each stage: ports for stage 0, previous stage registers otherwise.
    logic             st_v    [STAGES];
    logic             st_sub  [STAGES];
    logic             st_c    [STAGES];
    logic [WIDTH-1:0] st_a    [STAGES];
    logic [WIDTH-1:0] st_b    [STAGES];
    logic [WIDTH-1:0] st_sum  [STAGES];

    logic [SLICE-1:0] bx;
    logic [SLICE:0]   res;
    logic             adv;

`ifdef PIPELINED_ADDER_OVF_EN
    logic ovf_q;
    logic ovf_d;
`endif

    assign adv      = !valid_q[STAGES-1] || out_ready;
    assign in_ready = adv;

    always_comb begin
        st_v[0]   = in_valid;
        st_sub[0] = sub;
        st_c[0]   = sub | carry_in;
        st_a[0]   = a;
        st_b[0]   = b;
        st_sum[0] = '0;
        for (int k = 1; k < int'(STAGES); k++) begin
            st_v[k]   = valid_q[k-1];
            st_sub[k] = sub_q[k-1];
            st_c[k]   = carry_q[k-1];
            st_a[k]   = a_q[k-1];
            st_b[k]   = b_q[k-1];
            st_sum[k] = sum_q[k-1];
        end
    end

    // One slice added per stage; whole pipeline holds when the output is stalled.
    always_comb begin
        valid_d = valid_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        bx      = '0;
        res     = '0;
`ifdef PIPELINED_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (adv) begin
            for (int k = 0; k < int'(STAGES); k++) begin
                bx  = st_sub[k] ? ~st_b[k][SLICE-1:0] : st_b[k][SLICE-1:0];
                res = SW'(st_a[k][SLICE-1:0]) + SW'(bx) + SW'(st_c[k]);
                valid_d[k] = st_v[k];
                sub_d[k]   = st_sub[k];
                carry_d[k] = res[SLICE];
                a_d[k]     = st_a[k] >> SLICE;
                b_d[k]     = st_b[k] >> SLICE;
                sum_d[k]   = st_sum[k];
                sum_d[k][k*SLICE +: SLICE] = res[SLICE-1:0];
`ifdef PIPELINED_ADDER_OVF_EN
                // Carry into the MSB recovered from the MSB sum bit and its operands.
                if (k == int'(STAGES) - 1) begin
                    ovf_d = res[SLICE-1] ^ st_a[k][SLICE-1] ^ bx[SLICE-1] ^ res[SLICE];
                end
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '{default: 1'b0};
            sub_q   <= '{default: 1'b0};
            carry_q <= '{default: 1'b0};
            a_q     <= '{default: '0};
            b_q     <= '{default: '0};
            sum_q   <= '{default: '0};
        end else begin
            valid_q <= valid_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
        end
    end

`ifdef PIPELINED_ADDER_OVF_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign overflow = ovf_q;
`else
    assign overflow = 1'b0;
`endif

    assign out_valid = valid_q[STAGES-1];
    assign sum       = sum_q[STAGES-1];
    assign carry_out = carry_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder_sub.sv
// Bench for pipelined_adder_sub: directed 16-bit/4-stage cases plus random 8-bit sweeps at 1, 2, 8 stages.
module tb_pipelined_adder_sub;
`ifdef PIPELINED_ADDER_OVF_EN
    localparam bit OVF_ON = 1'b1;
`else
    localparam bit OVF_ON = 1'b0;
`endif

    typedef struct {
        logic [7:0] s;
        logic       c;
        logic       o;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    logic        d_in_valid, d_in_ready, d_carry_in, d_sub;
    logic        d_out_valid, d_out_ready, d_carry_out, d_overflow;
    logic [15:0] d_a, d_b, d_sum;

    logic       r_in_valid  [3];
    logic       r_in_ready  [3];
    logic       r_carry_in  [3];
    logic       r_sub       [3];
    logic       r_out_valid [3];
    logic       r_out_ready [3];
    logic       r_carry_out [3];
    logic       r_overflow  [3];
    logic [7:0] r_a   [3];
    logic [7:0] r_b   [3];
    logic [7:0] r_sum [3];

    pipelined_adder_sub #(.WIDTH(16), .STAGES(4)) u_dut (
        .clk(clk), .rst(rst), .in_valid(d_in_valid), .in_ready(d_in_ready),
        .a(d_a), .b(d_b), .carry_in(d_carry_in), .sub(d_sub),
        .out_valid(d_out_valid), .out_ready(d_out_ready), .sum(d_sum),
        .carry_out(d_carry_out), .overflow(d_overflow)
    );

    pipelined_adder_sub #(.WIDTH(8), .STAGES(1)) u_dut_s1 (
        .clk(clk), .rst(rst), .in_valid(r_in_valid[0]), .in_ready(r_in_ready[0]),
        .a(r_a[0]), .b(r_b[0]), .carry_in(r_carry_in[0]), .sub(r_sub[0]),
        .out_valid(r_out_valid[0]), .out_ready(r_out_ready[0]), .sum(r_sum[0]),
        .carry_out(r_carry_out[0]), .overflow(r_overflow[0])
    );

    pipelined_adder_sub #(.WIDTH(8), .STAGES(2)) u_dut_s2 (
        .clk(clk), .rst(rst), .in_valid(r_in_valid[1]), .in_ready(r_in_ready[1]),
        .a(r_a[1]), .b(r_b[1]), .carry_in(r_carry_in[1]), .sub(r_sub[1]),
        .out_valid(r_out_valid[1]), .out_ready(r_out_ready[1]), .sum(r_sum[1]),
        .carry_out(r_carry_out[1]), .overflow(r_overflow[1])
    );

    pipelined_adder_sub #(.WIDTH(8), .STAGES(8)) u_dut_s8 (
        .clk(clk), .rst(rst), .in_valid(r_in_valid[2]), .in_ready(r_in_ready[2]),
        .a(r_a[2]), .b(r_b[2]), .carry_in(r_carry_in[2]), .sub(r_sub[2]),
        .out_valid(r_out_valid[2]), .out_ready(r_out_ready[2]), .sum(r_sum[2]),
        .carry_out(r_carry_out[2]), .overflow(r_overflow[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Plain integer arithmetic: unsigned result/carry, signed range test for overflow.
    function automatic exp_t ref_model(input logic [7:0] x, input logic [7:0] y,
                                       input logic ci, input logic s);
        exp_t e;
        int ux, uy, sx, sy, r, sr;
        ux = int'(x);
        uy = int'(y);
        sx = int'($signed(x));
        sy = int'($signed(y));
        if (s) begin
            r   = ux - uy;
            sr  = sx - sy;
            e.c = (ux >= uy);
        end else begin
            r   = ux + uy + int'(ci);
            sr  = sx + sy + int'(ci);
            e.c = (r > 255);
        end
        e.s = 8'(r);
        e.o = OVF_ON && ((sr > 127) || (sr < -128));
        return e;
    endfunction

    task automatic run16(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tc, input logic ts, input logic [15:0] es,
                         input logic ec, input logic eo);
        @(negedge clk);
        d_a = ta; d_b = tb_v; d_carry_in = tc; d_sub = ts;
        d_in_valid = 1'b1; d_out_ready = 1'b1;
        @(negedge clk);
        d_in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_early"}, 32'(d_out_valid), 32'd0);
        @(negedge clk);
        check({tag, "_valid"}, 32'(d_out_valid), 32'd1);
        check({tag, "_sum"},   32'(d_sum),       32'(es));
        check({tag, "_cout"},  32'(d_carry_out), 32'(ec));
        check({tag, "_ovf"},   32'(d_overflow),  32'(eo));
    endtask

    task automatic sweep(input int idx, input int n_beats);
        exp_t q[$];
        exp_t e;
        int sent = 0;
        int got  = 0;
        for (int cyc = 0; cyc < 3000 && got < n_beats; cyc++) begin
            @(negedge clk);
            r_out_ready[idx] = ($urandom_range(0, 3) != 0);
            r_in_valid[idx]  = (sent < n_beats) && ($urandom_range(0, 2) != 0);
            r_a[idx]         = 8'($urandom);
            r_b[idx]         = 8'($urandom);
            r_carry_in[idx]  = 1'($urandom);
            r_sub[idx]       = 1'($urandom);
            #1;
            check("rnd_ready", 32'(r_in_ready[idx]),
                  32'(!r_out_valid[idx] || r_out_ready[idx]));
            if (r_out_valid[idx] && r_out_ready[idx]) begin
                if (q.size() == 0) begin
                    check("rnd_extra_beat", 32'd1, 32'd0);
                end else begin
                    e = q.pop_front();
                    check("rnd_sum",  32'(r_sum[idx]),       32'(e.s));
                    check("rnd_cout", 32'(r_carry_out[idx]), 32'(e.c));
                    check("rnd_ovf",  32'(r_overflow[idx]),  32'(e.o));
                    got++;
                end
            end
            if (r_in_valid[idx] && r_in_ready[idx]) begin
                q.push_back(ref_model(r_a[idx], r_b[idx], r_carry_in[idx], r_sub[idx]));
                sent++;
            end
        end
        check("rnd_done", 32'(got), 32'(n_beats));
        @(negedge clk);
        r_in_valid[idx]  = 1'b0;
        r_out_ready[idx] = 1'b1;
    endtask

    initial begin
        int sent, got, stall_left, seen;
        bit first_seen;
        rst = 1'b1;
        d_in_valid = 1'b0; d_a = '0; d_b = '0; d_carry_in = 1'b0; d_sub = 1'b0;
        d_out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            r_in_valid[i] = 1'b0; r_a[i] = '0; r_b[i] = '0;
            r_carry_in[i] = 1'b0; r_sub[i] = 1'b0; r_out_ready[i] = 1'b1;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(d_out_valid), 32'd0);
        check("rst_sum",   32'(d_sum),       32'd0);
        check("rst_cout",  32'(d_carry_out), 32'd0);
        check("rst_ovf",   32'(d_overflow),  32'd0);
        check("rst_ready", 32'(d_in_ready),  32'd1);
        for (int i = 0; i < 3; i++) check("rst_valid8", 32'(r_out_valid[i]), 32'd0);
        rst = 1'b0;

        run16("add_ff",   16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        run16("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
        run16("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, OVF_ON);
        run16("add_cin",  16'h1234, 16'h0F0F, 1'b1, 1'b0, 16'h2144, 1'b0, 1'b0);
        run16("sub_neg",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run16("sub_pos",  16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);

        // Eight back-to-back beats with a three-cycle stall after the first result.
        sent = 0; got = 0; stall_left = 0; first_seen = 1'b0;
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            @(negedge clk);
            if (d_out_valid && !first_seen) begin
                first_seen = 1'b1;
                stall_left = 3;
            end
            d_out_ready = (stall_left == 0);
            d_in_valid  = (sent < 8);
            d_a         = 16'(sent + 1);
            d_b         = 16'(16'h1000 * (sent + 1));
            d_carry_in  = 1'b0;
            d_sub       = 1'b0;
            #1;
            if (stall_left > 0) begin
                check("stall_ready", 32'(d_in_ready),  32'd0);
                check("stall_valid", 32'(d_out_valid), 32'd1);
                check("stall_sum",   32'(d_sum),       32'(16'h1001 * (got + 1)));
                stall_left--;
            end
            if (d_out_valid && d_out_ready) begin
                got++;
                check("stream_sum",  32'(d_sum),       32'(16'h1001 * got));
                check("stream_cout", 32'(d_carry_out), 32'd0);
            end
            if (d_in_valid && d_in_ready) sent++;
        end
        check("stream_count", 32'(got), 32'd8);
        d_in_valid = 1'b0;
        d_out_ready = 1'b1;
        seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (d_out_valid) seen++;
        end
        check("stream_no_dup", 32'(seen), 32'd0);

        // Three beats in flight, then one reset edge while a fourth beat is offered.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            d_in_valid = 1'b1;
            d_a = 16'(16'h0100 + i); d_b = 16'h0001; d_carry_in = 1'b0; d_sub = 1'b0;
            #1;
            check("mr_accept", 32'(d_in_ready), 32'd1);
        end
        @(negedge clk);
        rst = 1'b1;
        d_a = 16'hABCD;
        @(negedge clk);
        rst = 1'b0;
        d_in_valid = 1'b0;
        check("mr_valid", 32'(d_out_valid), 32'd0);
        check("mr_sum",   32'(d_sum),       32'd0);
        check("mr_cout",  32'(d_carry_out), 32'd0);
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (d_out_valid) seen++;
        end
        check("mr_ghost", 32'(seen), 32'd0);

        for (int i = 0; i < 3; i++) sweep(i, 80);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
